// File: rtl/tlc_pkg.sv
// Shared types for the traffic-light signal head driver: light codes, fault causes, lamp bit layout.
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        INVALID = 2'b11
    } light_t;

    typedef enum logic [2:0] {
        FC_NONE         = 3'b000,
        FC_CONFLICT     = 3'b001,
        FC_INVALID      = 3'b010,
        FC_SEQUENCE     = 3'b011,
        FC_SHORT_YELLOW = 3'b100
    } fault_code_t;

    localparam int unsigned LAMP_W   = 3;
    localparam int unsigned LAMP_RED = 2;
    localparam int unsigned LAMP_YEL = 1;
    localparam int unsigned LAMP_GRN = 0;

    localparam logic [LAMP_W-1:0] LAMP_OFF      = '0;
    localparam logic [LAMP_W-1:0] LAMP_RED_ONLY = LAMP_W'(1) << LAMP_RED;

    // An invalid code lights red so a broken controller never shows a go aspect.
    function automatic logic [LAMP_W-1:0] decode_lamp(input light_t code);
        logic [LAMP_W-1:0] lamp;
        lamp = LAMP_OFF;
        case (code)
            GREEN:   lamp[LAMP_GRN] = 1'b1;
            YELLOW:  lamp[LAMP_YEL] = 1'b1;
            default: lamp[LAMP_RED] = 1'b1;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/head_monitor.sv
// Per-head lamp decode, previous-code tracking, sequence check and (with MIN_YELLOW_CHECK_EN) yellow timer.
module head_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned MIN_YELLOW_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        code_i,
    input  logic              restart_i,
    output logic [LAMP_W-1:0] lamp_o_c,
    output logic              seq_err_o_c,
    output logic              short_yel_o_c
);

    light_t code;
    light_t prev_q, prev_d;

    if (MIN_YELLOW_CYCLES == 0) begin : g_bad_min_yellow
        $error("head_monitor: MIN_YELLOW_CYCLES must be at least 1");
    end

    assign code     = light_t'(code_i);
    assign lamp_o_c = decode_lamp(code);

    // Transitions involving INVALID never match any of these pairs, so they go unchecked.
    assign seq_err_o_c = ((prev_q == GREEN)  && (code == RED))    ||
                         ((prev_q == YELLOW) && (code == GREEN))  ||
                         ((prev_q == RED)    && (code == YELLOW));

    assign prev_d = restart_i ? RED : code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RED;
        end else begin
            prev_q <= prev_d;
        end
    end

`ifdef MIN_YELLOW_CHECK_EN
    localparam int unsigned YCW = $clog2(MIN_YELLOW_CYCLES + 1);
    localparam logic [YCW-1:0] YEL_MIN = YCW'(MIN_YELLOW_CYCLES);

    logic [YCW-1:0] ycnt_q, ycnt_d;

    // Consecutive yellow cycles, saturating once the minimum is met.
    always_comb begin
        ycnt_d = '0;
        if (!restart_i && (code == YELLOW)) begin
            ycnt_d = (ycnt_q == YEL_MIN) ? ycnt_q : ycnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ycnt_q <= '0;
        end else begin
            ycnt_q <= ycnt_d;
        end
    end

    assign short_yel_o_c = (prev_q == YELLOW) && (code == RED) && (ycnt_q < YEL_MIN);
`else
    assign short_yel_o_c = 1'b0;
`endif

endmodule

// File: rtl/signal_head_driver.sv
// Signal head driver: mirrors both heads onto lamps and drops to a red fault flash on conflicts or bad sequences.
// Optional minimum-yellow check is enabled by defining MIN_YELLOW_CHECK_EN.
module signal_head_driver
    import tlc_pkg::*;
#(
    parameter int unsigned FLASH_HALF_PERIOD = 10,
    parameter int unsigned MIN_YELLOW_CYCLES = 16,
    parameter int unsigned CONFLICT_FILTER   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] highway_light,
    input  logic [1:0] farm_light,
    input  logic       fault_clear,
    output logic [2:0] hwy_lamp,
    output logic [2:0] farm_lamp,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned FCW = $clog2(FLASH_HALF_PERIOD);
    localparam int unsigned PCW = $clog2(CONFLICT_FILTER + 1);
    localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_HALF_PERIOD - 1);
    localparam logic [PCW-1:0] FILT_LAST  = PCW'(CONFLICT_FILTER - 1);

    localparam logic [0:0] ST_MON   = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    if (FLASH_HALF_PERIOD < 2 || CONFLICT_FILTER < 1) begin : g_bad_param
        $error("signal_head_driver: FLASH_HALF_PERIOD must be >= 2 and CONFLICT_FILTER >= 1");
    end

    logic [0:0]        state_q, state_d;
    logic [FCW-1:0]    flash_cnt_q, flash_cnt_d;
    logic              flash_on_q, flash_on_d;
    logic [PCW-1:0]    conf_cnt_q, conf_cnt_d;
    logic [PCW-1:0]    inv_cnt_q, inv_cnt_d;
    logic [LAMP_W-1:0] hwy_lamp_q, hwy_lamp_d, farm_lamp_q, farm_lamp_d;
    logic              fault_q, fault_d;
    fault_code_t       fault_code_q, fault_code_d, fault_sel_c;

    logic [LAMP_W-1:0] hwy_dec_c, farm_dec_c;
    logic              hwy_seq_c, farm_seq_c, hwy_short_c, farm_short_c;
    logic              restart_c, conflict_c, invalid_c, both_red_c;
    light_t            hwy_code, farm_code;

    head_monitor #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_hwy (
        .clk(clk), .rst_n(rst_n), .code_i(highway_light), .restart_i(restart_c),
        .lamp_o_c(hwy_dec_c), .seq_err_o_c(hwy_seq_c), .short_yel_o_c(hwy_short_c)
    );

    head_monitor #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_farm (
        .clk(clk), .rst_n(rst_n), .code_i(farm_light), .restart_i(restart_c),
        .lamp_o_c(farm_dec_c), .seq_err_o_c(farm_seq_c), .short_yel_o_c(farm_short_c)
    );

    assign hwy_code   = light_t'(highway_light);
    assign farm_code  = light_t'(farm_light);
    assign conflict_c = ((hwy_code == GREEN)  || (hwy_code == YELLOW)) &&
                        ((farm_code == GREEN) || (farm_code == YELLOW));
    assign invalid_c  = (hwy_code == INVALID) || (farm_code == INVALID);
    assign both_red_c = (hwy_code == RED) && (farm_code == RED);

    // Highest-priority fault seen this cycle.
    always_comb begin
        fault_sel_c = FC_NONE;
        if (conflict_c && (conf_cnt_q == FILT_LAST)) begin
            fault_sel_c = FC_CONFLICT;
        end else if (invalid_c && (inv_cnt_q == FILT_LAST)) begin
            fault_sel_c = FC_INVALID;
        end else if (hwy_seq_c || farm_seq_c) begin
            fault_sel_c = FC_SEQUENCE;
        end else if (hwy_short_c || farm_short_c) begin
            fault_sel_c = FC_SHORT_YELLOW;
        end
    end

    always_comb begin
        state_d      = state_q;
        flash_cnt_d  = flash_cnt_q;
        flash_on_d   = flash_on_q;
        hwy_lamp_d   = hwy_lamp_q;
        farm_lamp_d  = farm_lamp_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        restart_c    = 1'b0;
        conf_cnt_d   = conflict_c ? ((conf_cnt_q == FILT_LAST) ? conf_cnt_q : conf_cnt_q + 1'b1) : '0;
        inv_cnt_d    = invalid_c  ? ((inv_cnt_q  == FILT_LAST) ? inv_cnt_q  : inv_cnt_q  + 1'b1) : '0;

        case (state_q)
            ST_MON: begin
                hwy_lamp_d  = hwy_dec_c;
                farm_lamp_d = farm_dec_c;
                if (fault_sel_c != FC_NONE) begin
                    state_d      = ST_FLASH;
                    fault_d      = 1'b1;
                    fault_code_d = fault_sel_c;
                    flash_cnt_d  = '0;
                    flash_on_d   = 1'b1;
                    hwy_lamp_d   = LAMP_RED_ONLY;
                    farm_lamp_d  = LAMP_RED_ONLY;
                end
            end
            ST_FLASH: begin
                // Leaving the flash is only safe while the controller itself shows all-red.
                if (fault_clear && both_red_c) begin
                    state_d      = ST_MON;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                    flash_cnt_d  = '0;
                    flash_on_d   = 1'b0;
                    conf_cnt_d   = '0;
                    inv_cnt_d    = '0;
                    restart_c    = 1'b1;
                    hwy_lamp_d   = hwy_dec_c;
                    farm_lamp_d  = farm_dec_c;
                end else begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        flash_on_d  = ~flash_on_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                    end
                    hwy_lamp_d  = flash_on_d ? LAMP_RED_ONLY : LAMP_OFF;
                    farm_lamp_d = flash_on_d ? LAMP_RED_ONLY : LAMP_OFF;
                end
            end
            default: state_d = ST_MON;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_MON;
            flash_cnt_q  <= '0;
            flash_on_q   <= 1'b0;
            conf_cnt_q   <= '0;
            inv_cnt_q    <= '0;
            hwy_lamp_q   <= LAMP_RED_ONLY;
            farm_lamp_q  <= LAMP_RED_ONLY;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_on_q   <= flash_on_d;
            conf_cnt_q   <= conf_cnt_d;
            inv_cnt_q    <= inv_cnt_d;
            hwy_lamp_q   <= hwy_lamp_d;
            farm_lamp_q  <= farm_lamp_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign hwy_lamp   = hwy_lamp_q;
    assign farm_lamp  = farm_lamp_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_signal_head_driver.sv
// Directed bench for signal_head_driver with default parameters; MIN_YELLOW_CHECK_EN selects the short-yellow expectation.
module tb_signal_head_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] highway_light;
    logic [1:0] farm_light;
    logic       fault_clear;
    logic [2:0] hwy_lamp;
    logic [2:0] farm_lamp;
    logic       fault;
    logic [2:0] fault_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    signal_head_driver dut (
        .clk(clk), .rst_n(rst_n),
        .highway_light(highway_light), .farm_light(farm_light), .fault_clear(fault_clear),
        .hwy_lamp(hwy_lamp), .farm_lamp(farm_lamp), .fault(fault), .fault_code(fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] h, input logic [2:0] f,
                           input logic flt, input logic [2:0] code);
        chk({tag, ".hwy_lamp"},   32'(hwy_lamp),   32'(h));
        chk({tag, ".farm_lamp"},  32'(farm_lamp),  32'(f));
        chk({tag, ".fault"},      32'(fault),      32'(flt));
        chk({tag, ".fault_code"}, 32'(fault_code), 32'(code));
    endtask

    // Drive one cycle of inputs and return just after the capturing edge.
    task automatic cyc(input logic [1:0] h, input logic [1:0] f, input logic clr);
        highway_light = h;
        farm_light    = f;
        fault_clear   = clr;
        @(posedge clk);
        #1;
        fault_clear   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        highway_light = 2'b10;
        farm_light    = 2'b10;
        fault_clear   = 1'b0;
        #12;
        chk_out("reset", 3'b100, 3'b100, 1'b0, 3'b000);
        rst_n = 1'b1;

        // Legal cycle HG/FR -> HY -> HR/FG -> FY -> HG
        repeat (3)  begin cyc(2'b00, 2'b10, 1'b0); chk_out("hg_fr", 3'b001, 3'b100, 1'b0, 3'b000); end
        repeat (21) begin cyc(2'b01, 2'b10, 1'b0); chk_out("hy_fr", 3'b010, 3'b100, 1'b0, 3'b000); end
        repeat (3)  begin cyc(2'b10, 2'b00, 1'b0); chk_out("hr_fg", 3'b100, 3'b001, 1'b0, 3'b000); end
        repeat (21) begin cyc(2'b10, 2'b01, 1'b0); chk_out("hr_fy", 3'b100, 3'b010, 1'b0, 3'b000); end
        repeat (3)  begin cyc(2'b00, 2'b10, 1'b0); chk_out("hg_fr2", 3'b001, 3'b100, 1'b0, 3'b000); end

        // A single invalid cycle is filtered out
        cyc(2'b00, 2'b11, 1'b0); chk_out("inv1", 3'b001, 3'b100, 1'b0, 3'b000);
        cyc(2'b00, 2'b10, 1'b0); chk_out("inv1_after", 3'b001, 3'b100, 1'b0, 3'b000);
        cyc(2'b00, 2'b10, 1'b0); chk_out("inv1_after2", 3'b001, 3'b100, 1'b0, 3'b000);

        // Two-cycle green/green conflict
        cyc(2'b00, 2'b00, 1'b0); chk_out("conf_c1", 3'b001, 3'b001, 1'b0, 3'b000);
        cyc(2'b00, 2'b00, 1'b0); chk_out("conf_flash0", 3'b100, 3'b100, 1'b1, 3'b001);
        for (int i = 1; i < 20; i++) begin
            cyc(2'b10, 2'b10, 1'b0);
            if (i < 10) chk_out("flash_on",  3'b100, 3'b100, 1'b1, 3'b001);
            else        chk_out("flash_off", 3'b000, 3'b000, 1'b1, 3'b001);
        end
        cyc(2'b10, 2'b10, 1'b0); chk_out("flash_on2", 3'b100, 3'b100, 1'b1, 3'b001);

        // fault_clear ignored without all-red, honoured with it, ignored in MON
        cyc(2'b00, 2'b10, 1'b1); chk_out("clr_ignored", 3'b100, 3'b100, 1'b1, 3'b001);
        cyc(2'b10, 2'b10, 1'b1); chk_out("clr_taken", 3'b100, 3'b100, 1'b0, 3'b000);
        cyc(2'b10, 2'b10, 1'b1); chk_out("clr_in_mon", 3'b100, 3'b100, 1'b0, 3'b000);

        // Illegal highway G->R
        cyc(2'b00, 2'b10, 1'b0); chk_out("seq_pre", 3'b001, 3'b100, 1'b0, 3'b000);
        cyc(2'b10, 2'b10, 1'b0); chk_out("seq_fault", 3'b100, 3'b100, 1'b1, 3'b011);
        repeat (12) cyc(2'b10, 2'b10, 1'b0);
        chk_out("seq_flash_off", 3'b000, 3'b000, 1'b1, 3'b011);

        // Asynchronous reset during the dark flash phase
        #2 rst_n = 1'b0;
        #1 chk_out("rst_mid", 3'b100, 3'b100, 1'b0, 3'b000);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Five-cycle yellow then red
        cyc(2'b00, 2'b10, 1'b0); chk_out("sy_green", 3'b001, 3'b100, 1'b0, 3'b000);
        repeat (5) begin cyc(2'b01, 2'b10, 1'b0); chk_out("sy_yellow", 3'b010, 3'b100, 1'b0, 3'b000); end
        cyc(2'b10, 2'b10, 1'b0);
`ifdef MIN_YELLOW_CHECK_EN
        chk_out("short_yellow", 3'b100, 3'b100, 1'b1, 3'b100);
`else
        chk_out("short_yellow_off", 3'b100, 3'b100, 1'b0, 3'b000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signal_head_driver.md
SIGNAL_HEAD_DRIVER -- requirements
Module: signal_head_driver

Interface
REQ-001 The block SHALL have parameter FLASH_HALF_PERIOD, default 10, meaning cycles per on/off half of the fault red flash.
REQ-002 The block SHALL have parameter MIN_YELLOW_CYCLES, default 16, meaning the minimum legal yellow duration in cycles.
REQ-003 The block SHALL have parameter CONFLICT_FILTER, default 2, meaning the consecutive cycles a conflict or invalid code must persist before a fault.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port highway_light, input, 2 bits: the highway head code (00 green, 01 yellow, 10 red, 11 invalid).
REQ-007 The block SHALL have port farm_light, input, 2 bits: the farm head code, same encoding as highway_light.
REQ-008 The block SHALL have port fault_clear, input, 1 bit: a single-cycle request to leave the fault flash.
REQ-009 The block SHALL have port hwy_lamp, output, 3 bits: highway lamp drives {red, yellow, green}, one-hot or all-off.
REQ-010 The block SHALL have port farm_lamp, output, 3 bits: farm lamp drives, same format as hwy_lamp.
REQ-011 The block SHALL have port fault, output, 1 bit: high while in the FLASH state.
REQ-012 The block SHALL have port fault_code, output, 3 bits: the latched cause (000 none, 001 conflict, 010 invalid, 011 sequence, 100 short yellow).

Function
REQ-013 The FSM SHALL have two states: MON and FLASH.
REQ-014 In MON, lamps SHALL be registered decodes of the inputs with exactly one-cycle latency (00->001, 01->010, 10->100, 11->100, i.e. invalid shows red).
REQ-015 A conflict SHALL be both heads in green or yellow; persisting CONFLICT_FILTER consecutive cycles SHALL trigger fault 001.
REQ-016 Code 11 on either head persisting CONFLICT_FILTER consecutive cycles SHALL trigger fault 010; a persistence counter SHALL reset on any clean cycle.
REQ-017 Per head, legal transitions SHALL be G->G, G->Y, Y->Y, Y->R, R->R, R->G; G->R, Y->G and R->Y SHALL trigger fault 011 on the cycle observed; transitions to or from 11 SHALL NOT be sequence-checked.
REQ-018 When several faults arise in the same cycle, fault_code SHALL take the highest priority in the order 001 > 010 > 011 > 100.
REQ-019 A fault detected in cycle N SHALL set state FLASH, fault=1 and fault_code at edge N+1; fault_code SHALL hold until leaving FLASH; further faults SHALL NOT overwrite it.
REQ-020 In FLASH, both heads SHALL show red-only (100) for FLASH_HALF_PERIOD cycles, then all-off for FLASH_HALF_PERIOD cycles, repeating, starting with red on the first FLASH cycle.
REQ-021 fault_clear in FLASH SHALL be honoured only when both inputs equal 10 in that same cycle; it then SHALL return to MON, clear fault and fault_code, and restart the persistence and yellow counters, with lamps following the inputs from the next edge.
REQ-022 fault_clear SHALL be ignored in MON, and in FLASH unless both inputs are red.
REQ-023 The flash counter SHALL be $clog2(FLASH_HALF_PERIOD) bits wide, wrapping to 0 at FLASH_HALF_PERIOD-1.

Reset
REQ-024 Asserting rst_n low SHALL, at any time including mid-flash, immediately force state MON, hwy_lamp=100, farm_lamp=100, fault=0, fault_code=000, and all counters to 0.
REQ-025 Reset SHALL set the per-head previous-code registers to red, so a first observed green after reset SHALL be legal.

Configuration
REQ-026 With MIN_YELLOW_CHECK_EN defined, each head SHALL count consecutive yellow cycles (saturating at MIN_YELLOW_CYCLES), and a Y->R transition with count < MIN_YELLOW_CYCLES SHALL trigger fault 100.
REQ-027 Without MIN_YELLOW_CHECK_EN, the yellow counter SHALL be absent and code 100 SHALL never occur.

Structure
REQ-028 Package tlc_pkg SHALL hold the light-code typedef (GREEN, YELLOW, RED, INVALID), the fault-code typedef and the lamp bit-index constants.
REQ-029 Sub-module head_monitor (decode, previous code, sequence check, yellow timer) SHALL be instantiated once per head; the FSM, the conflict filter and the flash timer SHALL live in the top level.

Verification
REQ-030 The bench SHALL drive a legal cycle HG/FR -> HY(21 cycles) -> HR/FG -> FY(21 cycles) -> HG and require the lamps to track the inputs with one-cycle latency, with fault=0 throughout.
REQ-031 The bench SHALL drive highway=00 and farm=00 for 2 cycles and require fault=1 and fault_code=001 on the next edge, with red flashing 10 on / 10 off.
REQ-032 The bench SHALL drive a highway change 00->10 and require fault_code=011 one cycle later; a single cycle of farm=11 SHALL produce no fault.
REQ-033 With MIN_YELLOW_CHECK_EN defined, the bench SHALL drive highway yellow for 5 cycles followed by red and require fault_code=100.
REQ-034 In FLASH, the bench SHALL pulse fault_clear with highway=00 and require it to be ignored, then pulse it with both inputs 10 and require MON with fault_code=000; an rst_n pulse mid-flash SHALL give lamps 100/100 immediately.
